// File: rtl/bn_fold_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bn_fold_pkg
//  Description : Shared types and helper functions for the batch-norm
//                parameter folder: FSM state encoding, output latency,
//                saturation bounds and channel-index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package bn_fold_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQRT = 3'd1,
        ST_DIV  = 3'd2,
        ST_BIAS = 3'd3,
        ST_OUT  = 3'd4
    } fold_state_e;

    // Rising edges from the input accept edge to out_valid.
    function automatic int fold_latency(input int dw, input int fb);
        return 2 * dw + fb + 2;
    endfunction

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bn_param_folder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bn_param_folder_if
//  Description : Handshake bundle for the BN parameter folder.
//                Input side : in_valid/in_ready + gamma, beta, mean, var.
//                Output side: out_valid/out_ready + weight, bias, channel,
//                             last flag.
//                slave  = folder view, master = producer/consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bn_param_folder_if #(
    parameter int NUM_FEATURES = 16,
    parameter int DATA_WIDTH   = 8
);
    localparam int CHW = bn_fold_pkg::chan_width(NUM_FEATURES);

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_gamma;
    logic signed [DATA_WIDTH-1:0] in_beta;
    logic signed [DATA_WIDTH-1:0] in_mean;
    logic signed [DATA_WIDTH-1:0] in_var;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_weight;
    logic signed [DATA_WIDTH-1:0] out_bias;
    logic [CHW-1:0]               out_channel;
    logic                         out_last;

    modport slave (
        input  in_valid, in_gamma, in_beta, in_mean, in_var, out_ready,
        output in_ready, out_valid, out_weight, out_bias, out_channel, out_last
    );

    modport master (
        output in_valid, in_gamma, in_beta, in_mean, in_var, out_ready,
        input  in_ready, out_valid, out_weight, out_bias, out_channel, out_last
    );

endinterface
`default_nettype wire

// File: rtl/bn_fold_divu.sv
`default_nettype none
// ============================================================================
//  Module      : bn_fold_divu
//  Description : Unsigned restoring divider, one quotient bit per cycle.
//                start (sampled while idle) loads operands; DVD_W cycles
//                later done pulses for one cycle with quotient valid.
//  Ports       : clk, rst (async, active-high), start, dividend, divisor,
//                busy, done, quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module bn_fold_divu #(
    parameter int DVD_W = 12,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DVS_W:0]   rem_sh, rem_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // The dividend shifts out of quo_q MSB-first while quotient bits
        // shift in at the bottom, so one register serves both roles.
        rem_sh  = {rem_q, quo_q[DVD_W-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        if (busy_q) begin
            if (rem_sh >= {1'b0, dvs_q}) begin
                rem_d = rem_sub[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CNT_W'(DVD_W);
            busy_d = 1'b1;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule
`default_nettype wire

// File: rtl/bn_param_folder.sv
`default_nettype none
// ============================================================================
//  Module      : bn_param_folder
//  Description : Folds raw batch-norm parameters (gamma, beta, mean, var)
//                into an effective weight/bias pair, one channel at a time:
//                  weff = sat(sign(g) * floor((|g| << FB) / floor(sqrt((var+EPS) << FB))))
//                  bias = sat(beta - ((mean * weff) >>> FB))
//  Ports       : clk, rst (async, active-high),
//                bus (bn_param_folder_if.slave): input and output handshakes
//  Revision    : 1.0 - initial release
// ============================================================================
module bn_param_folder
    import bn_fold_pkg::*;
#(
    parameter int NUM_FEATURES = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int FRAC_BITS    = 4,
    parameter int EPS          = 1
) (
    input  logic               clk,
    input  logic               rst,
    bn_param_folder_if.slave   bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int QW    = DATA_WIDTH + FRAC_BITS;
    localparam int BW    = 2 * DATA_WIDTH + 1;
    localparam int CHW   = chan_width(NUM_FEATURES);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CHW-1:0]          LAST_CH = CHW'(NUM_FEATURES - 1);
    localparam logic [CNT_W-1:0]        SQ_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W2-1:0]           EPS_W   = W2'(EPS);
    localparam logic signed [DW-1:0]    OUT_MAX = DW'(sat_max(DW));
    localparam logic signed [DW-1:0]    OUT_MIN = DW'(sat_min(DW));
    localparam logic signed [QW+1:0]    Q_MAX   = (QW+2)'(sat_max(DW));
    localparam logic signed [QW+1:0]    Q_MIN   = (QW+2)'(sat_min(DW));
    localparam logic signed [BW-1:0]    B_MAX   = BW'(sat_max(DW));
    localparam logic signed [BW-1:0]    B_MIN   = BW'(sat_min(DW));

    fold_state_e              state_q, state_d;
    logic signed [DW-1:0]     gamma_q, gamma_d, beta_q, beta_d, mean_q, mean_d;
    logic signed [DW-1:0]     weight_q, weight_d, bias_q, bias_d;
    logic [CHW-1:0]           chan_q, chan_d;
    logic [W2-1:0]            sq_x_q, sq_x_d;
    logic [DW+1:0]            sq_rem_q, sq_rem_d;
    logic [DW-1:0]            sq_root_q, sq_root_d;
    logic [CNT_W-1:0]         sq_cnt_q, sq_cnt_d;

    logic [W2-1:0]            var_s;
    logic [DW+3:0]            sq_rem_sh, sq_trial, sq_rem_diff;
    logic [DW-1:0]            gamma_abs;
    logic                     div_start, div_busy, div_done;
    logic [QW-1:0]            div_quot;
    logic signed [QW+1:0]     q_ext, q_s;
    logic signed [W2-1:0]     prod, prod_sh;
    logic signed [BW-1:0]     bias_full;

    // Negative variance is meaningless; clamp to zero before adding EPS.
    assign var_s       = (bus.in_var[DW-1] ? '0 : {{DW{1'b0}}, bus.in_var}) + EPS_W;
    // Digit-by-digit square root: two radicand bits enter per cycle.
    assign sq_rem_sh   = {sq_rem_q, sq_x_q[W2-1 -: 2]};
    assign sq_trial    = {2'b00, sq_root_q, 2'b01};
    assign sq_rem_diff = sq_rem_sh - sq_trial;
    assign gamma_abs   = gamma_q[DW-1] ? -gamma_q : gamma_q;
    assign q_ext       = {2'b00, div_quot};
    assign q_s         = gamma_q[DW-1] ? -q_ext : q_ext;
    assign prod        = W2'(mean_q) * W2'(weight_q);
    assign prod_sh     = prod >>> FRAC_BITS;
    assign bias_full   = {beta_q[DW-1], {(BW-DW-1){beta_q[DW-1]}}, beta_q} - {prod_sh[W2-1], prod_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gamma_q   <= '0;
            beta_q    <= '0;
            mean_q    <= '0;
            weight_q  <= '0;
            bias_q    <= '0;
            chan_q    <= '0;
            sq_x_q    <= '0;
            sq_rem_q  <= '0;
            sq_root_q <= '0;
            sq_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            gamma_q   <= gamma_d;
            beta_q    <= beta_d;
            mean_q    <= mean_d;
            weight_q  <= weight_d;
            bias_q    <= bias_d;
            chan_q    <= chan_d;
            sq_x_q    <= sq_x_d;
            sq_rem_q  <= sq_rem_d;
            sq_root_q <= sq_root_d;
            sq_cnt_q  <= sq_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gamma_d   = gamma_q;
        beta_d    = beta_q;
        mean_d    = mean_q;
        weight_d  = weight_q;
        bias_d    = bias_q;
        chan_d    = chan_q;
        sq_x_d    = sq_x_q;
        sq_rem_d  = sq_rem_q;
        sq_root_d = sq_root_q;
        sq_cnt_d  = sq_cnt_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    gamma_d   = bus.in_gamma;
                    beta_d    = bus.in_beta;
                    mean_d    = bus.in_mean;
                    sq_x_d    = var_s << FRAC_BITS;
                    sq_rem_d  = '0;
                    sq_root_d = '0;
                    sq_cnt_d  = '0;
                    state_d   = ST_SQRT;
                end
            end
            ST_SQRT: begin
                sq_x_d   = sq_x_q << 2;
                sq_cnt_d = sq_cnt_q + 1'b1;
                if (sq_rem_sh >= sq_trial) begin
                    sq_rem_d  = sq_rem_diff[DW+1:0];
                    sq_root_d = {sq_root_q[DW-2:0], 1'b1};
                end else begin
                    sq_rem_d  = sq_rem_sh[DW+1:0];
                    sq_root_d = {sq_root_q[DW-2:0], 1'b0};
                end
                // Launch the divider on the final root bit so the divisor is
                // taken straight from sq_root_d without an idle cycle.
                if (sq_cnt_q == SQ_LAST) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done && !div_busy) begin
                    if (sq_root_q == '0)
                        weight_d = gamma_q[DW-1] ? OUT_MIN : OUT_MAX;
                    else if (q_s > Q_MAX)
                        weight_d = OUT_MAX;
                    else if (q_s < Q_MIN)
                        weight_d = OUT_MIN;
                    else
                        weight_d = q_s[DW-1:0];
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                if (bias_full > B_MAX)
                    bias_d = OUT_MAX;
                else if (bias_full < B_MIN)
                    bias_d = OUT_MIN;
                else
                    bias_d = bias_full[DW-1:0];
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    chan_d  = (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    bn_fold_divu #(
        .DVD_W (QW),
        .DVS_W (DW)
    ) u_divu (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({gamma_abs, {FRAC_BITS{1'b0}}}),
        .divisor  (sq_root_d),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_OUT);
    assign bus.out_weight  = weight_q;
    assign bus.out_bias    = bias_q;
    assign bus.out_channel = chan_q;
    assign bus.out_last    = (chan_q == LAST_CH);

endmodule
`default_nettype wire

// File: doc/bn_param_folder.md
BN_PARAM_FOLDER -- requirements
Module: bn_param_folder

Interface
REQ-001 SHALL have parameter NUM_FEATURES, default 16, meaning the number of channels per folding pass.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the width of all signed fixed-point values.
REQ-003 SHALL have parameter FRAC_BITS, default 4, meaning the number of fractional bits in every value.
REQ-004 SHALL have parameter EPS, default 1, meaning epsilon as an integer in the same Q format; EPS shall be >= 1.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  raw BN parameter set is present.
REQ-008 in_ready  out  1  block can accept a parameter set.
REQ-009 in_gamma, in_beta, in_mean, in_var  in  DATA_WIDTH each  signed Qx.FRAC_BITS raw BN parameters.
REQ-010 out_valid  out  1  folded result is present.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_weight, out_bias  out  DATA_WIDTH each  signed effective_weight and effective_bias for the fused BN multiply-add.
REQ-013 out_channel  out  $clog2(NUM_FEATURES)  channel index of the current result.
REQ-014 out_last  out  1  high when out_channel == NUM_FEATURES-1.

Function
REQ-015 Input handshake SHALL complete on a rising edge with in_valid && in_ready; output handshake SHALL complete with out_valid && out_ready.
REQ-016 SHALL process one channel at a time using FSM IDLE -> SQRT -> DIV -> BIAS -> OUT -> IDLE.
REQ-017 In IDLE, in_ready=1; in all other states, in_ready=0.
REQ-018 On accept, SHALL register the inputs; a negative in_var SHALL be clamped to 0.
REQ-019 SHALL form s = var + EPS in unsigned 2*DATA_WIDTH bits.
REQ-020 SQRT SHALL take exactly DATA_WIDTH cycles, using bit-serial integer square root r = floor(sqrt(s << FRAC_BITS)).
REQ-021 DIV SHALL take exactly DATA_WIDTH+FRAC_BITS cycles, using restoring division q = floor((|gamma| << FRAC_BITS) / r).
REQ-022 The sign of gamma SHALL be applied to q (truncation toward zero).
REQ-023 The signed q SHALL be saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] to give weff.
REQ-024 BIAS SHALL take 1 cycle and compute bias = beta - ((mean*weff) >>> FRAC_BITS) in 2*DATA_WIDTH+1 bits, saturated to DATA_WIDTH.
REQ-025 out_valid SHALL rise exactly 2*DATA_WIDTH+FRAC_BITS+2 rising edges after the accept edge (22 at defaults).
REQ-026 In OUT, all outputs SHALL hold stable while out_ready=0; there SHALL be no timeout.
REQ-027 On the output handshake, the FSM SHALL return to IDLE and out_channel SHALL increment, wrapping from NUM_FEATURES-1 to 0.
REQ-028 If out_ready=1 is already high when out_valid rises, the handshake SHALL occur that cycle, and in_ready SHALL be 1 on the next cycle.
REQ-029 in_valid asserted while busy SHALL be ignored, with no state change.
REQ-030 r == 0 is unreachable (EPS >= 1 gives r >= 2^(FRAC_BITS/2)); RTL SHALL still force weff to saturate with the sign of gamma if r == 0.

Reset
REQ-031 rst SHALL asynchronously force: state=IDLE, in_ready=1, out_valid=0, out_weight=0, out_bias=0, out_channel=0, out_last=0, and SQRT/DIV datapath registers to 0.
REQ-032 rst mid-operation (any state) SHALL abort the channel with no output and restart channel numbering at 0.

Structure
REQ-033 Package bn_fold_pkg SHALL hold the FSM state enum and functions for latency and saturation bounds, parameterized by DATA_WIDTH/FRAC_BITS.
REQ-034 Restoring division SHALL be a sub-module bn_fold_divu (start/busy/done, unsigned dividend/divisor, quotient), instantiated once; square root SHALL be inline.

Verification (defaults, Q3.4 values as integers)
REQ-035 gamma=16, var=15, mean=32, beta=8 -> weight=16, bias=-24, out_valid 22 edges after accept, channel 0.
REQ-036 gamma=16, var=63, mean=-16, beta=0 -> weight=8, bias=8; gamma=16, var=47 -> r=27, weight=9 (truncation).
REQ-037 gamma=127, var=-5 (clamped), mean=127, beta=-128 -> weight=127 (saturated from 508), bias=-128 (saturated); gamma=-16, var=15, mean=0, beta=0 -> weight=-16, bias=0.
REQ-038 out_ready held low 10 cycles -> outputs stable, in_ready=0, extra in_valid ignored; release -> one handshake, then in_ready=1.
REQ-039 Stream 17 channels with NUM_FEATURES=16 -> out_last only on channel 15, channel 16 reported as 0.
REQ-040 Assert rst during DIV of channel 3 -> no output; next channel reports out_channel=0 with a correct result.
